// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants, state type and slot helper for the I2S DAC transmitter
package i2s_pkg;

  localparam int SLOT_BITS      = 32;
  localparam int FRAME_SCK      = 64;
  localparam int BEAT_W         = 128;
  localparam int LANES_PER_BEAT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter values during which a lane presents data (one-bit I2S delay after ws falls).
  function automatic logic in_data_window(input logic [5:0] cnt);
    return (cnt != 6'd0) && (cnt <= 6'(SLOT_BITS));
  endfunction

endpackage

// File: rtl/i2s_tx_lane.sv
// rtl/i2s_tx_lane.sv - one serial lane: load/shift register driving a registered MSB-first bit
module i2s_tx_lane
  import i2s_pkg::*;
#(
  parameter int W = SLOT_BITS
) (
  input  logic         i_sck,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_shift_en,
  output logic         o_sd
);

  logic [W-1:0] r_sr;
  logic         r_sd;

  always_ff @(posedge i_sck) begin
    if (i_clr) begin
      r_sr <= '0;
      r_sd <= 1'b0;
    end else if (i_load) begin
      r_sr <= i_load_data;
      r_sd <= 1'b0;
    end else if (i_shift_en) begin
      r_sd <= r_sr[W-1];
      r_sr <= {r_sr[W-2:0], 1'b0};
    end else begin
      r_sd <= 1'b0;
    end
  end

  assign o_sd = r_sd;

endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - eight-lane I2S transmitter fed by a 128-bit stream with a one-frame shadow buffer
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int SAMPLE_W  = SLOT_BITS
) (
  input  logic                               sck,
  input  logic                               rst,
  input  logic                               start,
  input  logic [LANES_PER_BEAT*SAMPLE_W-1:0] S_AXIS_tdata,
  input  logic                               S_AXIS_tvalid,
  input  logic                               S_AXIS_tlast,
  output logic                               S_AXIS_tready,
  output logic                               ws,
  output logic [NUM_LANES-1:0]               sd,
  output logic                               underrun,
  output logic                               frame_err
);

  localparam int BEATS = NUM_LANES / LANES_PER_BEAT;
  localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BW    = LANES_PER_BEAT * SAMPLE_W;

  state_t                      r_state;
  logic [5:0]                  r_cnt;
  logic                        r_ws;
  logic                        r_tready;
  logic                        r_underrun;
  logic                        r_frame_err;
  logic [BI_W-1:0]             r_beat;
  logic [NUM_LANES*SAMPLE_W-1:0] r_shadow;
  logic                        r_shadow_full;

  logic                        w_run_next;
  logic                        w_boundary;
  logic                        w_load;
  logic [5:0]                  w_cnt_next;
  logic                        w_shift_en;
  logic                        w_accept;
  logic                        w_last_beat;
  logic                        w_frame_err;
  logic                        w_frame_done;
  logic                        w_shadow_full_next;
  logic [NUM_LANES-1:0]        w_sd;

  assign w_run_next   = !rst && start;
  assign w_boundary   = w_run_next && ((r_state == IDLE) || (r_cnt == 6'(FRAME_SCK - 1)));
  assign w_load       = w_boundary && r_shadow_full;
  assign w_cnt_next   = (r_state == RUN) ? r_cnt + 6'd1 : 6'd0;
  assign w_shift_en   = w_run_next && in_data_window(w_cnt_next);
  assign w_accept     = S_AXIS_tvalid && r_tready;
  assign w_last_beat  = (r_beat == BI_W'(BEATS - 1));
  assign w_frame_err  = w_accept && (S_AXIS_tlast != w_last_beat);
  assign w_frame_done = w_accept && S_AXIS_tlast && w_last_beat;

  // tready is low while full, so a load and a completing frame never coincide.
  always_comb begin
    w_shadow_full_next = r_shadow_full;
    if (w_load) begin
      w_shadow_full_next = 1'b0;
    end else if (w_frame_done) begin
      w_shadow_full_next = 1'b1;
    end
  end

  always_ff @(posedge sck) begin
    if (!w_run_next) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_ws          <= 1'b0;
      r_tready      <= 1'b0;
      r_underrun    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_beat        <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
    end else begin
      r_state       <= RUN;
      r_cnt         <= w_cnt_next;
      r_ws          <= (w_cnt_next >= 6'(SLOT_BITS));
      r_tready      <= !w_shadow_full_next;
      r_underrun    <= w_boundary && !r_shadow_full;
      r_frame_err   <= w_frame_err;
      r_shadow_full <= w_shadow_full_next;
      if (w_frame_err || w_frame_done) begin
        r_beat <= '0;
      end else if (w_accept) begin
        r_beat <= r_beat + 1'b1;
      end
      if (w_accept && !w_frame_err) begin
        for (int b = 0; b < BEATS; b++) begin
          if (r_beat == BI_W'(b)) begin
            r_shadow[b*BW +: BW] <= S_AXIS_tdata;
          end
        end
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    i2s_tx_lane #(
      .W (SAMPLE_W)
    ) u_lane (
      .i_sck       (sck),
      .i_clr       (!w_run_next),
      .i_load      (w_boundary),
      .i_load_data (w_load ? r_shadow[l*SAMPLE_W +: SAMPLE_W] : {SAMPLE_W{1'b0}}),
      .i_shift_en  (w_shift_en),
      .o_sd        (w_sd[l])
    );
  end

  assign S_AXIS_tready = r_tready;
  assign ws            = r_ws;
  assign sd            = w_sd;
  assign underrun      = r_underrun;
  assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - directed self-checking bench for i2s_dac_tx
module tb_i2s_dac_tx;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } beat_t;

  localparam logic [255:0] F1  = {32'hDEADBEEF, 32'h80000000, 32'h00000001, 32'h12345678,
                                  32'hA5A5A5A5, 32'hFFFFFFFF, 32'h00000000, 32'h80000001};
  localparam logic [255:0] F2  = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
                                  32'h0F0F0F0F, 32'hF0F0F0F0, 32'h33333333, 32'hCCCCCCCC};
  localparam logic [255:0] F3  = {32'h55AA55AA, 32'hAA55AA55, 32'h00FF00FF, 32'hFF00FF00,
                                  32'h13579BDF, 32'h2468ACE0, 32'h7FFFFFFF, 32'hC0000003};
  localparam logic [255:0] F4  = {32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888,
                                  32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCD};
  localparam logic [255:0] F5  = {32'hCAFEBABE, 32'hFEEDFACE, 32'hBADC0FFE, 32'h0D15EA5E,
                                  32'h8BADF00D, 32'hDEADC0DE, 32'hABADCAFE, 32'h1BADB002};
  localparam logic [255:0] F6  = {32'h00000080, 32'h00008000, 32'h00800000, 32'h80000000,
                                  32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
  localparam logic [255:0] F7  = {32'hE1E2E3E4, 32'hD1D2D3D4, 32'hC1C2C3C4, 32'hB1B2B3B4,
                                  32'hA1A2A3A4, 32'h91929394, 32'h81828384, 32'h71727374};
  localparam logic [255:0] F8  = {32'h1234CDEF, 32'hF0F07777, 32'h0000FFFF, 32'hFFFF4000,
                                  32'h8765C321, 32'h5A5A5A5A, 32'hA5A5C5A5, 32'h3C3CFC3C};
  localparam logic [255:0] F9  = {8{32'hFFFFFFFF}};
  localparam logic [255:0] F10 = {32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F001,
                                  32'h0A0B0C0D, 32'hE0F01020, 32'h31415926, 32'h27182818};
  localparam logic [127:0] BAD0 = {4{32'hBAD0BAD0}};
  localparam logic [127:0] BAD1 = {4{32'hBAD1BAD1}};

  logic         sck = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] S_AXIS_tdata;
  logic         S_AXIS_tvalid;
  logic         S_AXIS_tlast;
  logic         S_AXIS_tready;
  logic         ws;
  logic [7:0]   sd;
  logic         underrun;
  logic         frame_err;

  int    n_checks = 0;
  int    n_errors = 0;
  string cur_tag  = "init";
  bit    gap_en   = 1'b0;
  bit    hold     = 1'b0;
  beat_t q[$];

  i2s_dac_tx dut (
    .sck           (sck),
    .rst           (rst),
    .start         (start),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tlast  (S_AXIS_tlast),
    .S_AXIS_tready (S_AXIS_tready),
    .ws            (ws),
    .sd            (sd),
    .underrun      (underrun),
    .frame_err     (frame_err)
  );

  always #5 sck = ~sck;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present the head of the beat queue at the falling edge; pop it once the rising edge took it.
  task automatic tick();
    bit acc;
    if (q.size() > 0 && (hold || !gap_en || $urandom_range(0, 2) != 0)) begin
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = q[0].data;
      S_AXIS_tlast  = q[0].last;
    end else begin
      S_AXIS_tvalid = 1'b0;
      S_AXIS_tdata  = '0;
      S_AXIS_tlast  = 1'b0;
    end
    acc  = S_AXIS_tvalid && S_AXIS_tready;
    hold = S_AXIS_tvalid && !acc;
    @(posedge sck);
    @(negedge sck);
    if (acc) void'(q.pop_front());
  endtask

  task automatic push_frame(input logic [255:0] fr);
    q.push_back('{data: fr[127:0],   last: 1'b0});
    q.push_back('{data: fr[255:128], last: 1'b1});
  endtask

  // tr_low >= 0: tready high for cnt < tr_low, low after; -1: only cnt 0 high and cnt 63 low.
  task automatic frame_check(input logic [255:0] fr, input bit ur, input int fe_cnt,
                             input int tr_low, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic [7:0] esd;
      tick();
      for (int l = 0; l < 8; l++) begin
        esd[l] = (c >= 1 && c <= 32) ? fr[l*32 + 32 - c] : 1'b0;
      end
      check($sformatf("%s cnt%0d {ws,sd,underrun,frame_err}", cur_tag, c),
            32'({ws, sd, underrun, frame_err}),
            32'({(c >= 32), esd, (ur && c == 0), (c == fe_cnt)}));
      if (tr_low >= 0) begin
        check($sformatf("%s cnt%0d tready", cur_tag, c), 32'(S_AXIS_tready), 32'(c < tr_low));
      end else if (c == 0 || c == 63) begin
        check($sformatf("%s cnt%0d tready", cur_tag, c), 32'(S_AXIS_tready), 32'(c == 0));
      end
    end
  endtask

  task automatic stop_check();
    start = 1'b0;
    tick();
    check({cur_tag, " stop {ws,sd,tready,underrun,frame_err}"},
          32'({ws, sd, S_AXIS_tready, underrun, frame_err}), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b1;
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = {4{32'hCAFEF00D}};
    S_AXIS_tlast  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge sck);
      @(negedge sck);
      check($sformatf("reset cyc%0d outputs", i),
            32'({ws, sd, S_AXIS_tready, underrun, frame_err}), 32'd0);
    end
    rst           = 1'b0;
    start         = 1'b0;
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast  = 1'b0;
    S_AXIS_tdata  = '0;

    cur_tag = "idle";
    push_frame(F1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("idle cyc%0d outputs", i),
            32'({ws, sd, S_AXIS_tready, underrun, frame_err}), 32'd0);
    end

    cur_tag = "single";
    start = 1'b1;
    frame_check('0, 1'b1, -1, 2, 64);
    frame_check(F1, 1'b0, -1, 64, 64);
    frame_check('0, 1'b1, -1, 64, 64);
    stop_check();

    cur_tag = "underrun";
    start = 1'b1;
    for (int f = 0; f < 3; f++) frame_check('0, 1'b1, -1, 64, 64);
    stop_check();

    cur_tag = "err_early_tlast";
    q.push_back('{data: BAD0, last: 1'b1});
    push_frame(F2);
    start = 1'b1;
    frame_check('0, 1'b1, 1, 3, 64);
    frame_check(F2, 1'b0, -1, 64, 64);
    stop_check();

    cur_tag = "err_missing_tlast";
    q.push_back('{data: BAD0, last: 1'b0});
    q.push_back('{data: BAD1, last: 1'b0});
    push_frame(F3);
    start = 1'b1;
    frame_check('0, 1'b1, 2, 4, 64);
    frame_check(F3, 1'b0, -1, 64, 64);
    stop_check();

    cur_tag = "back2back";
    gap_en = 1'b1;
    push_frame(F4);
    push_frame(F5);
    push_frame(F6);
    push_frame(F7);
    start = 1'b1;
    frame_check('0, 1'b1, -1, -1, 64);
    frame_check(F4, 1'b0, -1, -1, 64);
    frame_check(F5, 1'b0, -1, -1, 64);
    frame_check(F6, 1'b0, -1, -1, 64);
    frame_check(F7, 1'b0, -1, 64, 64);
    gap_en = 1'b0;
    stop_check();

    cur_tag = "stop_mid";
    push_frame(F8);
    start = 1'b1;
    frame_check('0, 1'b1, -1, 2, 64);
    push_frame(F9);
    frame_check(F8, 1'b0, -1, 2, 18);
    stop_check();

    cur_tag = "restart";
    push_frame(F10);
    start = 1'b1;
    frame_check('0, 1'b1, -1, 2, 64);
    frame_check(F10, 1'b0, -1, 64, 64);
    stop_check();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Eight-lane I2S transmitter: accepts 32-bit samples over an AXI4-Stream slave port and serializes one sample per lane per I2S frame onto eight serial data lines. The block also generates the word-select `ws`. It is the playback-side counterpart of the 8-lane ADC capture path. Its `sd`/`ws` outputs drive external DACs or a loopback into the capture wrapper. A two-frame buffer decouples stream arrival from the serial frame.

## Interface
- `NUM_LANES`, 8: serial data lanes. Must be a multiple of 4.
- `SAMPLE_W`, 32: bits per sample; also the slot width.
- `sck` in 1: bit clock. The only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level enable. 1 = run, 0 = idle.
- `S_AXIS_tdata` in 128: four samples per beat. Lane k mod 4 occupies bits [32(k mod 4)+31 : 32(k mod 4)].
- `S_AXIS_tvalid` in 1: beat valid.
- `S_AXIS_tlast` in 1: marks the last beat of a frame.
- `S_AXIS_tready` out 1: beat accepted when tvalid && tready on a rising `sck` edge.
- `ws` out 1: word select. 0 = left slot, 1 = right slot.
- `sd` out NUM_LANES: serial data, MSB first.
- `underrun` out 1: one-cycle pulse when a frame starts with no complete frame buffered.
- `frame_err` out 1: one-cycle pulse on a malformed stream frame.

## Operation
- **Frame format**
  - One stream frame = NUM_LANES/4 beats (2 for default).
  - Beat b carries lanes 4b..4b+3.
  - tlast is required on the final beat and only there.
- **States**
  - IDLE: entered on reset or whenever `start`=0.
  - RUN: entered from IDLE on an edge with `start`=1.
  - `start`=0 in RUN returns to IDLE on the next edge, regardless of position. This clears the bit counter, beat index, shadow and active buffers.
- **Bit counter**
  - 6-bit `cnt` is held at 0 in IDLE.
  - In RUN it increments each cycle and wraps 63→0.
- **Serial output**
  - ws = 0 for cnt 0..31 and 1 for cnt 32..63.
  - I2S one-bit delay: for cnt = c in 1..32, lane L drives bit (32−c) of its active sample.
  - For cnt 33..63 and cnt 0 (right slot), all lanes drive 0.
- **Shadow buffer**
  - NUM_LANES×32 bits, plus a `shadow_full` flag and a beat index.
  - tready = RUN && !shadow_full.
  - Each accepted beat writes its four lanes and increments the beat index.
  - Accepting the final beat with tlast=1 sets `shadow_full` and resets the beat index.
- **Frame errors**
  - Either case pulses frame_err, discards the partial frame and resets the beat index to 0:
    - tlast=1 on a non-final beat.
    - tlast=0 on the final beat.
  - `shadow_full` stays 0 after an error.
- **Load**
  - Evaluated on the edge where cnt goes 63→0, and on the IDLE→RUN edge.
  - Uses the registered `shadow_full` value from before that edge.
  - If 1: copy shadow to active and clear `shadow_full`.
  - If 0: set active to all zeros and pulse underrun. A frame completing on that same edge is loaded at the next boundary.
- **Reset values**
  - ws=0, sd=0, tready=0, underrun=0, frame_err=0.
  - State IDLE, cnt=0, buffers zero, `shadow_full`=0.

## Timing
- All outputs are registered on the rising edge of `sck`. Downstream samples on the following rising edge.
- Latency: first frame fully accepted before the IDLE→RUN edge gives `sd` = MSB one cycle after RUN entry (cnt=1).
- Latency in RUN: a frame completed during frame N is serialized in frame N+1.
- Sustained throughput: one frame per 64 `sck`. tready falls while `shadow_full`=1 and rises the cycle after the load.
- The underrun pulse coincides with cnt=0.
- The frame_err pulse occurs the cycle after the offending beat.

## Structure
- Package `i2s_pkg`:
  - constants SLOT_BITS=32, FRAME_SCK=64, BEAT_W=128, LANES_PER_BEAT=4.
  - state typedef {IDLE, RUN}.
- Sub-module `i2s_tx_lane`:
  - one per lane, generated.
  - 32-bit load/shift register.
  - inputs: load, load_data, shift enable (cnt 1..32).
  - output: MSB or 0.
- The top level holds the FSM, counter, shadow buffer and AXIS handshake.

## Test plan
- **Reset:** hold rst 3 cycles with start=1 and tvalid=1 → ws=0, sd=0x00, tready=0, underrun=0, frame_err=0 throughout.
- **Single frame:**
  - Stimulus: beat0 lanes 0..3 = 0x80000001, 0x00000000, 0xFFFFFFFF, 0xA5A5A5A5; beat1 (tlast) lanes 4..7 = 0x12345678, 0x1, 0x80000000, 0xDEADBEEF; then start.
  - Response: sd bit-exact over cnt 1..32; zeros over cnt 33..63 and cnt 0; ws toggles at cnt 0 and 32.
- **Underrun:** start with no stream data for 3 frames → sd all zero, underrun pulses at each cnt=0 (3 pulses).
- **Back-to-back:** 4 frames with random tvalid gaps → no underrun after the first load; tready low from `shadow_full` until the boundary; data order preserved.
- **Framing error:**
  - Stimulus: beat0 with tlast=1.
  - Response: frame_err pulse, nothing loaded. A following well-formed frame transmits correctly.
- **Stop mid-frame:** deassert start at cnt=17 → next edge ws=0, sd=0, tready=0. Restart with a fresh frame → transmission is clean from cnt=1.
